data_bridge_wr_mux: RTL and testbench
=====================================

DATA_BRIDGE_WR_MUX -- requirements
Module: data_bridge_wr_mux

Interface
REQ-001 SHALL have parameter NCH, default 4: local write channels, 2..8.
REQ-002 SHALL have parameter IDW, default 3: AXI ID width per channel.
REQ-003 SHALL have parameter DW, default 1024: data width, 512 or 1024; byte enables are DW/8.
REQ-004 SHALL have parameter TAGW, default 6: DMA tag width; 2**TAGW tags outstanding.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 lcl_wr_valid/first/last  in  NCH each  per-channel beat valid, burst first, burst last.
REQ-008 lcl_wr_ea  in  NCH*64; lcl_wr_axi_id  in  NCH*IDW; lcl_wr_be  in  NCH*DW/8; lcl_wr_data  in  NCH*DW  per-channel beat fields, channel i in slice i.
REQ-009 lcl_wr_ready  out  NCH  per-channel beat accept.
REQ-010 lcl_wr_rsp_valid  out  NCH; lcl_wr_rsp_axi_id  out  NCH*IDW; lcl_wr_rsp_last  out  NCH; lcl_wr_rsp_code  out  NCH (1 = error); lcl_wr_rsp_ready  in  NCH.
REQ-011 dma_wr_cmd_ready  in  1; dma_wr_cmd_valid  out  1; dma_wr_cmd_data  out  DW; dma_wr_cmd_be  out  DW/8; dma_wr_cmd_ea  out  64; dma_wr_cmd_tag  out  TAGW.
REQ-012 dma_wr_resp_valid  in  1; dma_wr_resp_tag  in  TAGW; dma_wr_resp_code  in  3  (no backpressure).
REQ-013 buf_empty  out  1  no tag allocated, response FIFO empty, dma_wr_cmd_valid low.
REQ-014 fir_bad_tag  out  1  sticky: response received for an unallocated tag.
REQ-015 debug_bus  out  NCH*64  per-channel {cmd count[31:0], rsp count[31:0]}.

Function
REQ-016 Arbitration SHALL be round-robin over lcl_wr_valid; grant held from granted channel's first beat through acceptance of its last beat; pointer then moves to winner+1 mod NCH.
REQ-017 lcl_wr_ready[i] SHALL be combinational: grant==i and free tag exists and (!dma_wr_cmd_valid or dma_wr_cmd_ready); all other channels 0.
REQ-018 Accepted beat SHALL appear on dma_wr_cmd_* the next cycle (1-cycle latency), held stable until dma_wr_cmd_ready; back-to-back beats at full rate when ready stays high.
REQ-019 Each beat SHALL take the lowest-index free tag; tag table stores {channel, axi_id, last}.
REQ-020 On dma_wr_resp_valid for an allocated tag: SHALL push {channel, axi_id, last, code!=0} into response FIFO and free tag; tag reusable next cycle.
REQ-021 Free and allocate in same cycle SHALL both occur (distinct tags); freed tag not visible to allocator that cycle.
REQ-022 Response for an unallocated tag SHALL be dropped and set fir_bad_tag until reset.
REQ-023 FIFO depth 2**TAGW SHALL never overflow (entries <= tags); head drives lcl_wr_rsp_valid[channel] only; pop on that channel's ready; head-of-line blocking intended.
REQ-024 Tags exhausted: all lcl_wr_ready SHALL be 0; grant retained mid-burst.
REQ-025 Out-of-order DMA responses SHALL be returned in DMA response order, not command order.

Reset
REQ-026 rst SHALL clear: all tags free, FIFO empty, grant none, pointer 0, dma_wr_cmd_valid 0, lcl_wr_rsp_valid 0, fir_bad_tag 0, counters 0; buf_empty 1.
REQ-027 rst mid-burst SHALL discard outstanding beats and responses without emitting any.

Configuration
REQ-028 Macro DATA_BRIDGE_WR_MUX_DEBUG_CNT_EN defined: per-channel 32-bit wrapping counters of accepted beats and returned responses drive debug_bus.
REQ-029 Macro undefined: no counters built; debug_bus tied to 0.

Structure
REQ-030 Shared package SHALL hold tag-table entry type, response-entry type and response code constants (OK=0, ERR=1).
REQ-031 Response FIFO SHALL be a sub-module data_bridge_rsp_fifo (parametric width/depth, push/pop/full/empty).

Verification
REQ-032 NCH=4; ch0 and ch2 each 3-beat bursts, same cycle -> dma beats ch0,ch0,ch0,ch2,ch2,ch2; tags 0..5.
REQ-033 TAGW=2; 6 beats, no responses -> 4 issued, lcl_wr_ready low; one response tag 1 -> next beat gets tag 1 the following cycle.
REQ-034 Responses tags 3,0,2 with code 0,5,0 -> lcl responses in order 3,0,2; tag 0 response code 1.
REQ-035 dma_wr_cmd_ready low 10 cycles -> dma_wr_cmd_* stable, no further lcl accept.
REQ-036 Response tag 7 unallocated -> no lcl response, fir_bad_tag 1; rst mid-burst -> buf_empty 1 next cycle, fir_bad_tag 0.

Source files
------------

// File: rtl/data_bridge_wr_mux_pkg.sv
// Shared types and constants for the write-channel mux: tag-table entry,
// response-FIFO entry, local response codes and the grant state encoding.
package data_bridge_wr_mux_pkg;

  // Widest channel index (NCH <= 8) and widest AXI ID carried in the tables.
  localparam int CH_MAXW = 3;
  localparam int IDW_MAX = 8;

  // Local response codes.
  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic {
    GRANT_IDLE  = 1'b0,
    GRANT_BURST = 1'b1
  } grant_state_t;

  // What we must remember about a beat while its DMA write is in flight.
  typedef struct packed {
    logic [CH_MAXW-1:0] ch;
    logic [IDW_MAX-1:0] axi_id;
    logic               last;
  } tag_entry_t;

  // One completed write waiting to be returned to its local channel.
  typedef struct packed {
    logic [CH_MAXW-1:0] ch;
    logic [IDW_MAX-1:0] axi_id;
    logic               last;
    logic               code;
  } rsp_entry_t;

  // Any non-zero DMA status collapses to a local error.
  function automatic logic rsp_code_of(input logic [2:0] dma_code);
    return (dma_code != 3'd0) ? RSP_ERR : RSP_OK;
  endfunction

endpackage

// File: rtl/data_bridge_rsp_fifo.sv
// Simple synchronous FIFO for returned write responses. DEPTH must be a
// power of two; push when full and pop when empty are ignored.
module data_bridge_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bridge_wr_mux.sv
// Round-robin mux of NCH local write channels onto one DMA write command
// port. Each accepted beat takes the lowest free tag; DMA responses are
// returned to the owning channel in DMA response order through a FIFO.
// Optional build macro DATA_BRIDGE_WR_MUX_DEBUG_CNT_EN adds per-channel
// beat/response counters on debug_bus; otherwise debug_bus is 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until accepted.
module data_bridge_wr_mux
  import data_bridge_wr_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int IDW  = 3,
  parameter int DW   = 1024,
  parameter int TAGW = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        lcl_wr_valid,
  input  logic [NCH-1:0]        lcl_wr_first,
  input  logic [NCH-1:0]        lcl_wr_last,
  input  logic [NCH*64-1:0]     lcl_wr_ea,
  input  logic [NCH*IDW-1:0]    lcl_wr_axi_id,
  input  logic [NCH*DW/8-1:0]   lcl_wr_be,
  input  logic [NCH*DW-1:0]     lcl_wr_data,
  output logic [NCH-1:0]        lcl_wr_ready,
  output logic [NCH-1:0]        lcl_wr_rsp_valid,
  output logic [NCH*IDW-1:0]    lcl_wr_rsp_axi_id,
  output logic [NCH-1:0]        lcl_wr_rsp_last,
  output logic [NCH-1:0]        lcl_wr_rsp_code,
  input  logic [NCH-1:0]        lcl_wr_rsp_ready,
  input  logic                  dma_wr_cmd_ready,
  output logic                  dma_wr_cmd_valid,
  output logic [DW-1:0]         dma_wr_cmd_data,
  output logic [DW/8-1:0]       dma_wr_cmd_be,
  output logic [63:0]           dma_wr_cmd_ea,
  output logic [TAGW-1:0]       dma_wr_cmd_tag,
  input  logic                  dma_wr_resp_valid,
  input  logic [TAGW-1:0]       dma_wr_resp_tag,
  input  logic [2:0]            dma_wr_resp_code,
  output logic                  buf_empty,
  output logic                  fir_bad_tag,
  output logic [NCH*64-1:0]     debug_bus
);

  localparam int CHW  = $clog2(NCH);
  localparam int NTAG = 2**TAGW;
  localparam int BEW  = DW/8;

  grant_state_t     grant_state;
  logic [CHW-1:0]   grant_ch;
  logic [CHW-1:0]   rr_ptr;
  logic             pick_valid;
  logic [CHW-1:0]   pick_ch;
  logic             cur_valid;
  logic [CHW-1:0]   cur_ch;
  logic             accept;
  logic             slot_ok;
  logic             credit_ok;
  logic [TAGW+1:0]  in_use;
  int               idx;

  logic [NTAG-1:0]  tag_busy;
  tag_entry_t       tag_tab [NTAG];
  logic [TAGW-1:0]  free_tag;
  logic [TAGW:0]    busy_cnt;
  logic             resp_hit;

  rsp_entry_t       push_ent;
  rsp_entry_t       head;
  logic [$bits(rsp_entry_t)-1:0] head_bits;
  logic [CHW-1:0]   head_ch;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAGW:0]    fifo_cnt;
  logic             unused_bits;

  // Round-robin pick among valid channels, starting at rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_valid && lcl_wr_valid[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = CHW'(idx);
      end
    end
  end

  assign cur_valid = (grant_state == GRANT_BURST) || pick_valid;
  assign cur_ch    = (grant_state == GRANT_BURST) ? grant_ch : pick_ch;
  assign slot_ok   = !dma_wr_cmd_valid || dma_wr_cmd_ready;

  // Count of tags in flight; each in-flight tag or queued response holds a credit.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NTAG; i++) busy_cnt = busy_cnt + {{TAGW{1'b0}}, tag_busy[i]};
  end

  // A beat may only start if tags plus queued responses (net of this cycle's
  // pop) stay within the FIFO depth, so the response FIFO can never overflow.
  assign in_use    = {1'b0, busy_cnt} + {1'b0, fifo_cnt} - {{(TAGW+1){1'b0}}, fifo_pop};
  assign credit_ok = (in_use < (TAGW+2)'(NTAG));

  // Ready goes only to the granted channel.
  always_comb begin
    lcl_wr_ready = '0;
    if (cur_valid && credit_ok && slot_ok) lcl_wr_ready[cur_ch] = 1'b1;
  end

  assign accept = |(lcl_wr_valid & lcl_wr_ready);

  // Lowest-index free tag; a tag freed this cycle is not yet visible here.
  always_comb begin
    free_tag = '0;
    for (int i = NTAG-1; i >= 0; i--) begin
      if (!tag_busy[i]) free_tag = TAGW'(i);
    end
  end

  // Grant state: hold the channel from its first beat until its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_state <= GRANT_IDLE;
      grant_ch    <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      if (lcl_wr_last[cur_ch]) begin
        grant_state <= GRANT_IDLE;
        rr_ptr      <= (cur_ch == CHW'(NCH-1)) ? '0 : cur_ch + CHW'(1);
      end else begin
        grant_state <= GRANT_BURST;
        grant_ch    <= cur_ch;
      end
    end
  end

  // DMA command register: load on accept, drop once the DMA takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_wr_cmd_valid <= 1'b0;
      dma_wr_cmd_data  <= '0;
      dma_wr_cmd_be    <= '0;
      dma_wr_cmd_ea    <= '0;
      dma_wr_cmd_tag   <= '0;
    end else if (accept) begin
      dma_wr_cmd_valid <= 1'b1;
      dma_wr_cmd_data  <= lcl_wr_data[int'(cur_ch)*DW +: DW];
      dma_wr_cmd_be    <= lcl_wr_be[int'(cur_ch)*BEW +: BEW];
      dma_wr_cmd_ea    <= lcl_wr_ea[int'(cur_ch)*64 +: 64];
      dma_wr_cmd_tag   <= free_tag;
    end else if (dma_wr_cmd_ready) begin
      dma_wr_cmd_valid <= 1'b0;
    end
  end

  assign resp_hit = dma_wr_resp_valid && tag_busy[dma_wr_resp_tag];

  // Tag ownership and the sticky bad-tag flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_busy    <= '0;
      fir_bad_tag <= 1'b0;
    end else begin
      if (resp_hit) tag_busy[dma_wr_resp_tag] <= 1'b0;
      if (accept)   tag_busy[free_tag]        <= 1'b1;
      if (dma_wr_resp_valid && !tag_busy[dma_wr_resp_tag]) fir_bad_tag <= 1'b1;
    end
  end

  // Tag table contents: only meaningful while the tag is busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_tab[free_tag] <= '{ch:     CH_MAXW'(cur_ch),
                             axi_id: IDW_MAX'(lcl_wr_axi_id[int'(cur_ch)*IDW +: IDW]),
                             last:   lcl_wr_last[cur_ch]};
    end
  end

  assign push_ent = '{ch:     tag_tab[dma_wr_resp_tag].ch,
                      axi_id: tag_tab[dma_wr_resp_tag].axi_id,
                      last:   tag_tab[dma_wr_resp_tag].last,
                      code:   rsp_code_of(dma_wr_resp_code)};

  data_bridge_rsp_fifo #(
    .W     ($bits(rsp_entry_t)),
    .DEPTH (NTAG)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_hit),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign head     = head_bits;
  assign head_ch  = head.ch[CHW-1:0];
  assign fifo_pop = !fifo_empty && lcl_wr_rsp_ready[head_ch];

  // Head of the FIFO is offered only to its own channel; the payload is
  // broadcast because only the valid bit selects a receiver.
  always_comb begin
    lcl_wr_rsp_valid = '0;
    if (!fifo_empty) lcl_wr_rsp_valid[head_ch] = 1'b1;
  end

  assign lcl_wr_rsp_axi_id = {NCH{head.axi_id[IDW-1:0]}};
  assign lcl_wr_rsp_last   = {NCH{head.last}};
  assign lcl_wr_rsp_code   = {NCH{head.code}};

  assign buf_empty   = (tag_busy == '0) && fifo_empty && !dma_wr_cmd_valid;
  assign unused_bits = ^{lcl_wr_first, head_bits, fifo_full};

`ifdef DATA_BRIDGE_WR_MUX_DEBUG_CNT_EN
  logic [31:0] cmd_cnt [NCH];
  logic [31:0] rsp_cnt [NCH];

  // Wrapping per-channel counters of accepted beats and returned responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cmd_cnt[i] <= '0;
        rsp_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept && cur_ch == CHW'(i))    cmd_cnt[i] <= cmd_cnt[i] + 32'd1;
        if (fifo_pop && head_ch == CHW'(i)) rsp_cnt[i] <= rsp_cnt[i] + 32'd1;
      end
    end
  end

  // Pack counters onto the debug bus.
  always_comb begin
    debug_bus = '0;
    for (int i = 0; i < NCH; i++) debug_bus[i*64 +: 64] = {cmd_cnt[i], rsp_cnt[i]};
  end
`else
  assign debug_bus = '0;
`endif

endmodule

// File: tb/tb_data_bridge_wr_mux.sv
// Directed bench for data_bridge_wr_mux: instance A (TAGW=3) covers
// arbitration, response ordering, backpressure, bad tags and reset;
// instance B (TAGW=2) covers tag exhaustion and tag reuse.
module tb_data_bridge_wr_mux;

  localparam int NCH = 4;
  localparam int IDW = 3;
  localparam int DW  = 512;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared local-side stimulus; sel_b routes valid to instance B
  logic                 sel_b;
  logic [NCH-1:0]       lv, lf, ll;
  logic [NCH*64-1:0]    lea;
  logic [NCH*IDW-1:0]   lid;
  logic [NCH*DW/8-1:0]  lbe;
  logic [NCH*DW-1:0]    ldata;
  logic [NCH-1:0]       valid_a, valid_b;
  logic [NCH-1:0]       rsp_ready;
  logic [2:0]           resp_code;

  assign valid_a = sel_b ? '0 : lv;
  assign valid_b = sel_b ? lv : '0;

  // Instance A signals
  logic [NCH-1:0]     ready_a, rsp_valid_a, rsp_last_a, rsp_code_a;
  logic [NCH*IDW-1:0] rsp_id_a;
  logic               cmd_ready_a, cmd_valid_a, resp_valid_a, buf_empty_a, fir_a;
  logic [DW-1:0]      cmd_data_a;
  logic [DW/8-1:0]    cmd_be_a;
  logic [63:0]        cmd_ea_a;
  logic [2:0]         cmd_tag_a, resp_tag_a;
  logic [NCH*64-1:0]  dbg_a;

  // Instance B signals
  logic [NCH-1:0]     ready_b, rsp_valid_b, rsp_last_b, rsp_code_b;
  logic [NCH*IDW-1:0] rsp_id_b;
  logic               cmd_ready_b, cmd_valid_b, resp_valid_b, buf_empty_b, fir_b;
  logic [DW-1:0]      cmd_data_b;
  logic [DW/8-1:0]    cmd_be_b;
  logic [63:0]        cmd_ea_b;
  logic [1:0]         cmd_tag_b, resp_tag_b;
  logic [NCH*64-1:0]  dbg_b;

  data_bridge_wr_mux #(.NCH(NCH), .IDW(IDW), .DW(DW), .TAGW(3)) u_dut_a (
    .clk (clk), .rst (rst),
    .lcl_wr_valid (valid_a), .lcl_wr_first (lf), .lcl_wr_last (ll),
    .lcl_wr_ea (lea), .lcl_wr_axi_id (lid), .lcl_wr_be (lbe), .lcl_wr_data (ldata),
    .lcl_wr_ready (ready_a),
    .lcl_wr_rsp_valid (rsp_valid_a), .lcl_wr_rsp_axi_id (rsp_id_a),
    .lcl_wr_rsp_last (rsp_last_a), .lcl_wr_rsp_code (rsp_code_a),
    .lcl_wr_rsp_ready (rsp_ready),
    .dma_wr_cmd_ready (cmd_ready_a), .dma_wr_cmd_valid (cmd_valid_a),
    .dma_wr_cmd_data (cmd_data_a), .dma_wr_cmd_be (cmd_be_a),
    .dma_wr_cmd_ea (cmd_ea_a), .dma_wr_cmd_tag (cmd_tag_a),
    .dma_wr_resp_valid (resp_valid_a), .dma_wr_resp_tag (resp_tag_a),
    .dma_wr_resp_code (resp_code),
    .buf_empty (buf_empty_a), .fir_bad_tag (fir_a), .debug_bus (dbg_a)
  );

  data_bridge_wr_mux #(.NCH(NCH), .IDW(IDW), .DW(DW), .TAGW(2)) u_dut_b (
    .clk (clk), .rst (rst),
    .lcl_wr_valid (valid_b), .lcl_wr_first (lf), .lcl_wr_last (ll),
    .lcl_wr_ea (lea), .lcl_wr_axi_id (lid), .lcl_wr_be (lbe), .lcl_wr_data (ldata),
    .lcl_wr_ready (ready_b),
    .lcl_wr_rsp_valid (rsp_valid_b), .lcl_wr_rsp_axi_id (rsp_id_b),
    .lcl_wr_rsp_last (rsp_last_b), .lcl_wr_rsp_code (rsp_code_b),
    .lcl_wr_rsp_ready (rsp_ready),
    .dma_wr_cmd_ready (cmd_ready_b), .dma_wr_cmd_valid (cmd_valid_b),
    .dma_wr_cmd_data (cmd_data_b), .dma_wr_cmd_be (cmd_be_b),
    .dma_wr_cmd_ea (cmd_ea_b), .dma_wr_cmd_tag (cmd_tag_b),
    .dma_wr_resp_valid (resp_valid_b), .dma_wr_resp_tag (resp_tag_b),
    .dma_wr_resp_code (resp_code),
    .buf_empty (buf_empty_b), .fir_bad_tag (fir_b), .debug_bus (dbg_b)
  );

  // Scoreboard: expected {tag[2:0], ea[63:0]} of each DMA command beat
  logic [66:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int n_issued = 0;
  int len [NCH];
  int idx [NCH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present each channel's current beat; ea = ch*256 + beat
  task automatic drive_lanes();
    for (int ch = 0; ch < NCH; ch++) begin
      lv[ch] = (idx[ch] < len[ch]);
      lf[ch] = (idx[ch] == 0);
      ll[ch] = (idx[ch] == len[ch] - 1);
      lea[ch*64 +: 64]    = 64'(ch*256 + idx[ch]);
      lid[ch*IDW +: IDW]  = 3'(ch + 1);
      lbe[ch*64 +: 64]    = '1;
      ldata[ch*DW +: DW]  = {8{64'(ch*256 + idx[ch])}};
    end
  endtask

  task automatic clear_lanes();
    for (int ch = 0; ch < NCH; ch++) begin
      len[ch] = 0;
      idx[ch] = 0;
    end
    drive_lanes();
  endtask

  // One clock: note which beats were accepted, advance those channels
  task automatic cycle();
    logic [NCH-1:0] acc;
    acc = (sel_b ? ready_b : ready_a) & lv;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) if (acc[ch]) idx[ch]++;
    drive_lanes();
    #1;
  endtask

  // Compare a presented DMA command beat against the scoreboard
  task automatic check_cmd();
    logic [66:0] obs;
    logic [66:0] exp;
    logic        v;
    v   = sel_b ? cmd_valid_b : cmd_valid_a;
    obs = sel_b ? {1'b0, cmd_tag_b, cmd_ea_b} : {cmd_tag_a, cmd_ea_a};
    if (v) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        chk("cmd_unexpected", 128'(1), 128'(0));
      end else begin
        exp = exp_q.pop_front();
        chk("cmd_tag_ea", 128'(obs), 128'(exp));
        chk("cmd_data", 128'(sel_b ? cmd_data_b[127:64] : cmd_data_a[127:64]), 128'(exp[63:0]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel_b = 1'b0;
    rsp_ready = '1;
    resp_code = 3'd0;
    cmd_ready_a = 1'b1;
    cmd_ready_b = 1'b1;
    resp_valid_a = 1'b0;
    resp_tag_a = '0;
    resp_valid_b = 1'b0;
    resp_tag_b = '0;
    clear_lanes();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_buf_empty_a", 128'(buf_empty_a), 128'(1));
    chk("rst_buf_empty_b", 128'(buf_empty_b), 128'(1));
    chk("rst_fir_a", 128'(fir_a), 128'(0));
    chk("rst_cmd_valid_a", 128'(cmd_valid_a), 128'(0));
    chk("rst_rsp_valid_a", 128'(rsp_valid_a), 128'(0));
    chk("rst_debug_a", 128'(|dbg_a), 128'(0));

    // ch0 and ch2 each 3 beats at once: ch0 burst then ch2 burst, tags 0..5
    len[0] = 3;
    len[2] = 3;
    drive_lanes();
    #1;
    for (int b = 0; b < 3; b++) exp_q.push_back({3'(b), 64'(b)});
    for (int b = 0; b < 3; b++) exp_q.push_back({3'(b + 3), 64'(512 + b)});
    repeat (10) begin
      cycle();
      check_cmd();
    end
    chk("rr_beats_issued", 128'(n_issued), 128'(6));
    chk("rr_queue_drained", 128'(exp_q.size()), 128'(0));
    chk("busy_not_empty", 128'(buf_empty_a), 128'(0));

    // Out-of-order responses: tags 3,0,2 with codes 0,5,0
    resp_valid_a = 1'b1;
    resp_tag_a = 3'd3;
    resp_code = 3'd0;
    cycle();
    resp_tag_a = 3'd0;
    resp_code = 3'd5;
    #1;
    chk("rsp1_valid", 128'(rsp_valid_a), 128'(4'b0100));
    chk("rsp1_id", 128'(rsp_id_a[8:6]), 128'(3));
    chk("rsp1_last", 128'(rsp_last_a[2]), 128'(0));
    chk("rsp1_code", 128'(rsp_code_a[2]), 128'(0));
    cycle();
    resp_tag_a = 3'd2;
    resp_code = 3'd0;
    #1;
    chk("rsp2_valid", 128'(rsp_valid_a), 128'(4'b0001));
    chk("rsp2_id", 128'(rsp_id_a[2:0]), 128'(1));
    chk("rsp2_last", 128'(rsp_last_a[0]), 128'(0));
    chk("rsp2_code", 128'(rsp_code_a[0]), 128'(1));
    cycle();
    resp_valid_a = 1'b0;
    #1;
    chk("rsp3_valid", 128'(rsp_valid_a), 128'(4'b0001));
    chk("rsp3_last", 128'(rsp_last_a[0]), 128'(1));
    chk("rsp3_code", 128'(rsp_code_a[0]), 128'(0));
    cycle();
    chk("rsp_drained", 128'(rsp_valid_a), 128'(0));

    // Response for unallocated tag 7 (busy tags are 1,4,5)
    resp_valid_a = 1'b1;
    resp_tag_a = 3'd7;
    cycle();
    resp_valid_a = 1'b0;
    #1;
    chk("bad_tag_fir", 128'(fir_a), 128'(1));
    chk("bad_tag_no_rsp", 128'(rsp_valid_a), 128'(0));
    cycle();
    chk("bad_tag_sticky", 128'(fir_a), 128'(1));
    chk("bad_tag_no_rsp2", 128'(rsp_valid_a), 128'(0));

    // DMA backpressure: ch1 first beat takes lowest free tag 0, then stalls
    cmd_ready_a = 1'b0;
    len[1] = 4;
    drive_lanes();
    #1;
    cycle();
    chk("stall_first_valid", 128'(cmd_valid_a), 128'(1));
    chk("stall_first_beat", 128'({cmd_tag_a, cmd_ea_a}), 128'({3'd0, 64'h100}));
    repeat (10) begin
      cycle();
      chk("stall_valid", 128'(cmd_valid_a), 128'(1));
      chk("stall_beat", 128'({cmd_tag_a, cmd_ea_a}), 128'({3'd0, 64'h100}));
      chk("stall_no_ready", 128'(ready_a), 128'(0));
      chk("stall_no_accept", 128'(idx[1]), 128'(1));
    end
    cmd_ready_a = 1'b1;
    #1;
    chk("stall_release_ready", 128'(ready_a), 128'(4'b0010));

    // Reset in the middle of the ch1 burst
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_lanes();
    #1;
    chk("midrst_buf_empty", 128'(buf_empty_a), 128'(1));
    chk("midrst_fir", 128'(fir_a), 128'(0));
    chk("midrst_cmd_valid", 128'(cmd_valid_a), 128'(0));
    chk("midrst_rsp_valid", 128'(rsp_valid_a), 128'(0));
    cycle();
    chk("midrst_quiet", 128'({cmd_valid_a, rsp_valid_a}), 128'(0));

    // Instance B, 4 tags: 6-beat burst stops after 4 beats
    sel_b = 1'b1;
    n_issued = 0;
    len[1] = 6;
    drive_lanes();
    #1;
    for (int b = 0; b < 4; b++) exp_q.push_back({3'(b), 64'(256 + b)});
    repeat (8) begin
      cycle();
      check_cmd();
    end
    chk("exhaust_issued", 128'(n_issued), 128'(4));
    chk("exhaust_no_ready", 128'(ready_b), 128'(0));
    chk("exhaust_grant_held", 128'(idx[1]), 128'(4));

    // Free tag 1: not usable this cycle, usable the next
    resp_valid_b = 1'b1;
    resp_tag_b = 2'd1;
    resp_code = 3'd0;
    #1;
    chk("reuse_not_yet", 128'(ready_b), 128'(0));
    cycle();
    resp_valid_b = 1'b0;
    #1;
    chk("reuse_rsp_valid", 128'(rsp_valid_b), 128'(4'b0010));
    chk("reuse_ready", 128'(ready_b), 128'(4'b0010));
    exp_q.push_back({3'd1, 64'h104});
    cycle();
    check_cmd();
    chk("reuse_issued", 128'(n_issued), 128'(5));
    chk("reuse_full_again", 128'(ready_b), 128'(0));
    chk("b_fir_clear", 128'(fir_b), 128'(0));
    chk("b_debug", 128'(|dbg_b), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
